// File: rtl/poly_note_tracker_if.sv
// Purpose : bundles the scan-code input, mix controls and voice outputs of poly_note_tracker.
// Latency : n/a (wires only).
// Backpressure: none; code_valid is a one-cycle strobe and the tracker always accepts it.
// Ports   : code/code_valid/dual/off (+ oct_up/oct_dn when NOTE_OCTAVE_EN) in,
//           voice_freq/voice_act/mix_freq/overflow out (slave = tracker side).
interface poly_note_tracker_if #(
    parameter int VOICES = 2,
    parameter int FW     = 16
);
    logic [7:0]           code;
    logic                 code_valid;
    logic                 dual;
    logic                 off;
`ifdef NOTE_OCTAVE_EN
    logic                 oct_up;
    logic                 oct_dn;
`endif
    logic [VOICES*FW-1:0] voice_freq;
    logic [VOICES-1:0]    voice_act;
    logic [FW-1:0]        mix_freq;
    logic                 overflow;

    modport master (
        output code, code_valid, dual, off,
`ifdef NOTE_OCTAVE_EN
        output oct_up, oct_dn,
`endif
        input  voice_freq, voice_act, mix_freq, overflow
    );

    modport slave (
        input  code, code_valid, dual, off,
`ifdef NOTE_OCTAVE_EN
        input  oct_up, oct_dn,
`endif
        output voice_freq, voice_act, mix_freq, overflow
    );
endinterface

// File: rtl/poly_note_tracker.sv
// Purpose : decodes PS/2 make/break bytes into VOICES held-note slots with age ranks and a mixed frequency.
// Latency : slot/voice_act/overflow update 1 cycle after the final byte strobe; frequencies combinational from slots.
// Backpressure: none; every code_valid byte is consumed in its cycle.
// Ports   : clk, clrn (async active-low), bus (poly_note_tracker_if.slave).
// Option  : define NOTE_OCTAVE_EN to add oct_up/oct_dn and a saturating octave in {-1,0,+1}.
module poly_note_tracker #(
    parameter int VOICES = 2,
    parameter int FW     = 16
) (
    input  logic               clk,
    input  logic               clrn,
    poly_note_tracker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;

    state_t            state;
    logic [3:0]        slot_note [VOICES];
    // rank 0 = oldest; active slots always hold ranks 0..n_act-1
    logic [1:0]        slot_rank [VOICES];
    logic [VOICES-1:0] slot_act;
    logic              ovf_q;
`ifdef NOTE_OCTAVE_EN
    logic signed [1:0] octave;
`endif

    // {mapped, table index}
    function automatic logic [4:0] lookup(input logic [7:0] c);
        case (c)
            8'h16: lookup = {1'b1, 4'd0};
            8'h1E: lookup = {1'b1, 4'd1};
            8'h26: lookup = {1'b1, 4'd2};
            8'h25: lookup = {1'b1, 4'd3};
            8'h2E: lookup = {1'b1, 4'd4};
            8'h36: lookup = {1'b1, 4'd5};
            8'h3D: lookup = {1'b1, 4'd6};
            8'h3E: lookup = {1'b1, 4'd7};
            8'h46: lookup = {1'b1, 4'd8};
            8'h45: lookup = {1'b1, 4'd9};
            8'h4E: lookup = {1'b1, 4'd10};
            8'h55: lookup = {1'b1, 4'd11};
            default: lookup = 5'd0;
        endcase
    endfunction

    function automatic logic [9:0] freq_of(input logic [3:0] idx);
        case (idx)
            4'd0:    freq_of = 10'd357;
            4'd1:    freq_of = 10'd378;
            4'd2:    freq_of = 10'd401;
            4'd3:    freq_of = 10'd425;
            4'd4:    freq_of = 10'd450;
            4'd5:    freq_of = 10'd477;
            4'd6:    freq_of = 10'd505;
            4'd7:    freq_of = 10'd535;
            4'd8:    freq_of = 10'd567;
            4'd9:    freq_of = 10'd601;
            4'd10:   freq_of = 10'd636;
            default: freq_of = 10'd674;
        endcase
    endfunction

    logic          map_ok;
    logic [3:0]    map_idx;
    logic          held_hit;
    logic [1:0]    held_slot, held_rank;
    logic          free_found;
    logic [1:0]    free_slot, oldest_slot;
    logic [2:0]    n_act;

    always_comb begin
        {map_ok, map_idx} = lookup(bus.code);
        held_hit    = 1'b0;
        held_slot   = 2'd0;
        held_rank   = 2'd0;
        free_found  = 1'b0;
        free_slot   = 2'd0;
        oldest_slot = 2'd0;
        n_act       = 3'd0;
        for (int i = 0; i < VOICES; i++) begin
            if (slot_act[i]) begin
                n_act = n_act + 3'd1;
                if (slot_note[i] == map_idx) begin
                    held_hit  = 1'b1;
                    held_slot = 2'(i);
                    held_rank = slot_rank[i];
                end
                if (slot_rank[i] == 2'd0)
                    oldest_slot = 2'(i);
            end
        end
        // descending scan so the lowest free index wins
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!slot_act[i]) begin
                free_found = 1'b1;
                free_slot  = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            slot_act <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                slot_note[i] <= 4'd0;
                slot_rank[i] <= 2'd0;
            end
`ifdef NOTE_OCTAVE_EN
            octave   <= 2'sd0;
`endif
        end else begin
            ovf_q <= 1'b0;
`ifdef NOTE_OCTAVE_EN
            if (bus.oct_up && !bus.oct_dn && octave != 2'sd1)
                octave <= octave + 2'sd1;
            else if (bus.oct_dn && !bus.oct_up && octave != -2'sd1)
                octave <= octave - 2'sd1;
`endif
            if (bus.code_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.code == 8'hF0)
                            state <= BRK;
                        else if (bus.code == 8'hE0)
                            state <= EXT;
                        else if (map_ok && !held_hit) begin
                            if (free_found) begin
                                for (int i = 0; i < VOICES; i++) begin
                                    if (2'(i) == free_slot) begin
                                        slot_act[i]  <= 1'b1;
                                        slot_note[i] <= map_idx;
                                        slot_rank[i] <= n_act[1:0];
                                    end
                                end
                            end else begin
                                // all slots busy: steal the oldest, everyone else ages by one
                                ovf_q <= 1'b1;
                                for (int i = 0; i < VOICES; i++) begin
                                    if (2'(i) == oldest_slot) begin
                                        slot_note[i] <= map_idx;
                                        slot_rank[i] <= 2'(VOICES - 1);
                                    end else begin
                                        slot_rank[i] <= slot_rank[i] - 2'd1;
                                    end
                                end
                            end
                        end
                    end
                    BRK: begin
                        state <= IDLE;
                        if (map_ok && held_hit) begin
                            for (int i = 0; i < VOICES; i++) begin
                                if (2'(i) == held_slot) begin
                                    slot_act[i]  <= 1'b0;
                                    slot_rank[i] <= 2'd0;
                                end else if (slot_act[i] && slot_rank[i] > held_rank) begin
                                    slot_rank[i] <= slot_rank[i] - 2'd1;
                                end
                            end
                        end
                    end
                    EXT:     state <= (bus.code == 8'hF0) ? EXTBRK : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [FW-1:0]   vf_raw [VOICES];
    logic [FW+1:0]   sum, avg;
    logic [FW-1:0]   newest, mix;
    logic [VOICES*FW-1:0] vf_packed;

    always_comb begin
        sum       = '0;
        newest    = '0;
        vf_packed = '0;
        for (int i = 0; i < VOICES; i++) begin
            vf_raw[i] = FW'(freq_of(slot_note[i]));
`ifdef NOTE_OCTAVE_EN
            if (octave == 2'sd1)
                vf_raw[i] = vf_raw[i] << 1;
            else if (octave == -2'sd1)
                vf_raw[i] = vf_raw[i] >> 1;
`endif
            if (!slot_act[i])
                vf_raw[i] = '0;
            vf_packed[i*FW +: FW] = vf_raw[i];
            sum = sum + {2'b00, vf_raw[i]};
            if (slot_act[i] && {1'b0, slot_rank[i]} == n_act - 3'd1)
                newest = vf_raw[i];
        end
        case (n_act)
            3'd1:    avg = sum;
            3'd2:    avg = sum >> 1;
            3'd3:    avg = sum / (FW+2)'(3);
            3'd4:    avg = sum >> 2;
            default: avg = '0;
        endcase
        mix = bus.dual ? FW'(avg) : newest;
    end

    assign bus.voice_freq = bus.off ? '0 : vf_packed;
    assign bus.mix_freq   = bus.off ? '0 : mix;
    assign bus.voice_act  = slot_act;
    assign bus.overflow   = ovf_q;
endmodule

// File: doc/poly_note_tracker.md
POLY_NOTE_TRACKER -- requirements
Module: poly_note_tracker

Interface
REQ-001 SHALL have parameter VOICES, default 2, number of note slots (legal 1..4).
REQ-002 SHALL have parameter FW, default 16, frequency word width (legal >= 12).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port code  input  8  PS/2 scan-code byte.
REQ-006 SHALL have port code_valid  input  1  one-cycle strobe qualifying code.
REQ-007 SHALL have port dual  input  1  mix mode: 1 = average of held voices, 0 = newest voice.
REQ-008 SHALL have port off  input  1  mute.
REQ-009 SHALL have port voice_freq  output  VOICES*FW  per-slot frequency word, slot i at bits [i*FW +: FW].
REQ-010 SHALL have port voice_act  output  VOICES  per-slot held flag.
REQ-011 SHALL have port mix_freq  output  FW  mixed frequency word.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse when a make code steals a slot.

Function
REQ-013 SHALL map codes 16,1E,26,25,2E,36,3D,3E,46,45,4E,55 (hex) to 357,378,401,425,450,477,505,535,567,601,636,674; all other codes unmapped.
REQ-014 SHALL decode bytes with FSM IDLE/BRK/EXT/EXTBRK: F0 in IDLE->BRK; E0 in IDLE->EXT; F0 in EXT->EXTBRK; any other byte in BRK, EXT or EXTBRK -> IDLE.
REQ-015 SHALL treat a non-F0/E0 byte in IDLE as a make, in BRK as a break, and in EXT or EXTBRK as discarded.
REQ-016 SHALL ignore unmapped make/break codes; the FSM still advances.
REQ-017 SHALL ignore a make for a code already held (typematic repeat): no slot or age change.
REQ-018 SHALL place a new make in the lowest-index free slot; if none is free, it SHALL replace the oldest slot and pulse overflow.
REQ-019 SHALL track age as a per-slot rank (0..VOICES-1): the newly written slot gets the newest rank; ranks of other active slots newer than a freed or replaced slot shift by one.
REQ-020 SHALL clear the slot holding a break's code; a break for an unheld code SHALL be ignored.
REQ-021 SHALL make slot, voice_act and overflow updates visible on the cycle after the code_valid of the final byte.
REQ-022 SHALL drive voice_freq of an inactive slot as 0.
REQ-023 with dual=1, mix_freq SHALL be floor(sum of active voice frequencies / active count), summed at FW+2 bits; 0 when none active.
REQ-024 with dual=0, mix_freq SHALL be the newest active voice frequency; 0 when none active.
REQ-025 mix_freq SHALL be combinational from slot registers (no extra latency).
REQ-026 off=1 SHALL force voice_freq and mix_freq to 0 combinationally; tracking, voice_act and overflow SHALL continue unaffected.

Reset
REQ-027 clrn low SHALL immediately set FSM to IDLE, clear all slots and ranks, and set voice_act=0, voice_freq=0, mix_freq=0, overflow=0, octave=0.
REQ-028 reset mid-sequence (e.g. after F0) SHALL discard the partial sequence; the first byte after release SHALL be decoded from IDLE.

Configuration
REQ-029 with macro NOTE_OCTAVE_EN defined, SHALL add inputs oct_up and oct_dn (1 bit, one-cycle pulses) and a registered octave in {-1,0,+1}, saturating at the limits.
REQ-030 oct_up and oct_dn asserted in the same cycle SHALL leave octave unchanged; an octave pulse coincident with code_valid SHALL apply both updates.
REQ-031 with octave +1, table values SHALL be shifted left by 1; with -1, shifted right by 1 (truncating); the change SHALL apply to held voices on the next cycle.
REQ-032 without NOTE_OCTAVE_EN, the oct ports SHALL be absent and octave fixed at 0.

Verification
REQ-033 Bytes 1C,16 -> slot0 act, voice_freq[0]=357, mix_freq=357 one cycle after the 16 strobe.
REQ-034 With dual=1: makes 16,1E -> mix=367; then F0,16 -> voice_act=10b, mix=378.
REQ-035 With VOICES=2: makes 16,1E,26 -> overflow pulses once, slot0=401, slot1=378; with dual=0 -> mix=401.
REQ-036 Sequence E0,16 then E0,F0,16 -> no slot change; repeated make 16 ×3 -> one slot only.
REQ-037 Bytes 16 then F0 then clrn low then 16 -> after release, 16 is a make (slot0=357), not a break.
REQ-038 NOTE_OCTAVE_EN: make 55, oct_up ×2 -> 1348; oct_dn ×3 -> 337; off=1 -> all frequency outputs 0, voice_act=1.
